// File: rtl/aes_key_expander_if.sv
// Key-schedule control and round-key read port. master = key consumer, slave = expander.
interface aes_key_expander_if #(
  parameter int KEY_BITS = 256
);
  logic [KEY_BITS-1:0] key_in;
  logic                start;
  logic                busy;
  logic                keys_valid;
  logic                dec_order;
  logic [3:0]          rk_addr;
  logic [127:0]        rk_data;

  modport master (
    output key_in, start, dec_order, rk_addr,
    input  busy, keys_valid, rk_data
  );

  modport slave (
    input  key_in, start, dec_order, rk_addr,
    output busy, keys_valid, rk_data
  );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/256 key schedule: one 32-bit word per cycle into a register file, combinational round-key read.
// keys_valid follows the start edge by 40 (AES-128) or 52 (AES-256) cycles; start is ignored while busy.
module aes_key_expander #(
  parameter int KEY_BITS = 256
) (
  input logic               clk,
  input logic               rst,
  aes_key_expander_if.slave kif
);
  localparam int NK     = KEY_BITS / 32;
  localparam int NR     = NK + 6;
  localparam int NWORDS = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128 or 256");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load;
  logic [31:0] w [NWORDS];
  logic [5:0]  idx;
  logic [7:0]  rcon;
  logic        rot_step;
  logic        sub_step;
  logic [31:0] prev_w;
  logic [31:0] temp;
  logic [31:0] new_w;
  logic [3:0]  eff_addr;
  logic [5:0]  base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (kif.start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (idx == 6'(NWORDS - 1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign kif.busy       = (state == EXPAND);
  assign kif.keys_valid = (state == DONE);

  // Next schedule word; AES-256 adds a bare SubWord halfway through each 8-word group.
  always_comb begin
    prev_w   = w[idx - 6'd1];
    rot_step = ((idx & 6'(NK - 1)) == 6'd0);
    sub_step = (NK == 8) && (idx[2:0] == 3'd4);
    temp     = prev_w;
    if (rot_step) begin
      temp = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
    end else if (sub_step) begin
      temp = sub_word(prev_w);
    end
    new_w = w[idx - 6'(NK)] ^ temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      rcon <= 8'h01;
      for (int i = 0; i < NWORDS; i++) begin
        w[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NK; i++) begin
        w[i] <= kif.key_in[KEY_BITS-1-32*i -: 32];
      end
      idx  <= 6'(NK);
      rcon <= 8'h01;
    end else if (state == EXPAND) begin
      w[idx] <= new_w;
      idx    <= idx + 6'd1;
      if (rot_step) begin
        rcon <= xtime(rcon);
      end
    end
  end

  // Decrypt order mirrors the round index; out-of-range addresses read as zero.
  always_comb begin
    eff_addr    = kif.dec_order ? (4'(NR) - kif.rk_addr) : kif.rk_addr;
    base        = {eff_addr, 2'b00};
    kif.rk_data = '0;
    if (kif.rk_addr <= 4'(NR)) begin
      kif.rk_data = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end
  end
endmodule
